// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit sequencer states and default line timing.
// Latency: none, constants and types only.
// Backpressure: none, no datapath here.
package uart_pkg;

  // Encodings of the transmit request sequencer
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_REQ  = 1'b1;

  // Default board clock and line rate, shared with ip_uart and the future RX block
  localparam int CLK_FREQ  = 27000000;
  localparam int UART_FREQ = 115200;

  typedef enum logic {
    TX_IDLE = ST_IDLE,
    TX_REQ  = ST_REQ
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_ram.sv
// Byte storage for the UART transmit FIFO: one write port, one read port.
// Latency: write lands on the clock edge, read is combinational at rd_addr.
// Backpressure: none, the caller gates wr_en with its own full/flush logic.
module uart_tx_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  logic [7:0] mem [2**DEPTH_LOG2];

  // Contents need no reset: only entries counted by the level are ever read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of ip_uart, draining in order via send_req/send_busy.
// Latency: a byte pushed into an empty FIFO raises send_req one edge later.
// Backpressure: wr_ready = not full (registered level); send_req holds until send_busy is low.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  overflow_clear,
  output logic [7:0]            send_data,
  output logic                  send_req,
  input  logic                  send_busy
);

  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [7:0]            rd_data;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  tx_state_e             state;

  // Full/empty come from the registered level, so a same-edge pop never frees a slot early
  assign full     = (level == LEVEL_FULL);
  assign empty    = (level == '0);
  assign wr_ready = ~full;

  // Flush wins over both sides: the concurrent push is dropped and the sequencer cannot pop
  assign push = wr_valid & ~full & ~flush;
  assign pop  = (state == TX_IDLE) & ~empty & ~flush;

  uart_tx_fifo_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow; a write attempt against a full FIFO beats a same-edge clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_valid & full & ~flush) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

  // Request sequencer: pop into a held request, release it once ip_uart is not busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= TX_IDLE;
      send_req  <= 1'b0;
      send_data <= 8'h00;
    end else begin
      case (state)
        TX_IDLE: begin
          if (pop) begin
            send_data <= rd_data;
            send_req  <= 1'b1;
            state     <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (!send_busy) begin
            send_req <= 1'b0;
            state    <= TX_IDLE;
          end
        end
        default: begin
          send_req <= 1'b0;
          state    <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small ip_uart busy model.
// Latency: inputs change and outputs are sampled on the falling clock edge.
// Backpressure: the producer retries while wr_ready is low.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       flush;
  logic [4:0] level;
  logic       overflow;
  logic       overflow_clear;
  logic [7:0] send_data;
  logic       send_req;
  logic       send_busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_q[$];
  int         unstable;
  logic       stab_prev_req;
  logic [7:0] stab_held;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .flush          (flush),
    .level          (level),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .send_data      (send_data),
    .send_req       (send_req),
    .send_busy      (send_busy)
  );

  always #5 clk = ~clk;

  // Tracks whether send_data moves while a request is held
  function automatic void stab_sample();
    if (send_req === 1'b1 && stab_prev_req === 1'b1 && send_data !== stab_held)
      unstable++;
    stab_held     = send_data;
    stab_prev_req = send_req;
  endfunction

  // ip_uart stand-in: accepts on req && !busy, then stays busy for blen (or random 1..30) cycles
  task automatic uart_model(input int nbytes, input int blen, input bit rnd);
    int waited;
    int len;
    for (int n = 0; n < nbytes; n++) begin
      waited = 0;
      while (!(send_req === 1'b1 && send_busy === 1'b0)) begin
        if (waited >= 400) begin
          total++; bad++;
          $display("FAIL uart_timeout: byte %0d never requested, got %0d of %0d", n, rx_q.size(), nbytes);
          return;
        end
        @(negedge clk); stab_sample(); waited++;
      end
      rx_q.push_back(send_data);
      @(negedge clk); stab_sample();
      send_busy = 1'b1;
      len = rnd ? int'($urandom_range(30, 1)) : blen;
      repeat (len) begin
        @(negedge clk); stab_sample();
      end
      send_busy = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_data = 8'h00; wr_valid = 1'b0; flush = 1'b0;
    overflow_clear = 1'b0; send_busy = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    total++; if (send_req !== 1'b0) begin bad++; $display("FAIL reset_send_req: got %b want 0", send_req); end
    total++; if (send_data !== 8'h00) begin bad++; $display("FAIL reset_send_data: got %h want 00", send_data); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hi();
    rx_q.delete(); unstable = 0; stab_prev_req = 1'b0;
    fork
      begin
        wr_data = 8'h48; wr_valid = 1'b1;
        @(negedge clk);
        total++; if (send_req !== 1'b0) begin bad++; $display("FAIL hi_req_early: got %b want 0", send_req); end
        wr_data = 8'h69;
        @(negedge clk);
        wr_valid = 1'b0;
        total++; if (send_req !== 1'b1) begin bad++; $display("FAIL hi_req_latency: got %b want 1", send_req); end
        total++; if (send_data !== 8'h48) begin bad++; $display("FAIL hi_first_data: got %h want 48", send_data); end
      end
      uart_model(2, 20, 1'b0);
    join
    total++; if (rx_q.size() != 2) begin bad++; $display("FAIL hi_count: got %0d want 2", rx_q.size()); end
    total++; if (rx_q.size() < 1 || rx_q[0] !== 8'h48) begin bad++; $display("FAIL hi_byte0: got %h want 48", (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
    total++; if (rx_q.size() < 2 || rx_q[1] !== 8'h69) begin bad++; $display("FAIL hi_byte1: got %h want 69", (rx_q.size() > 1) ? rx_q[1] : 8'hxx); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL hi_level_end: got %0d want 0", level); end
    total++; if (unstable != 0) begin bad++; $display("FAIL hi_data_stable: got %0d changes want 0", unstable); end
  endtask

  task automatic test_fill_overflow();
    send_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'(i); wr_valid = 1'b1;
      @(negedge clk);
    end
    total++; if (level !== 5'd16) begin bad++; $display("FAIL fill_level: got %0d want 16", level); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fill_wr_ready: got %b want 0", wr_ready); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_no_overflow: got %b want 0", overflow); end
    total++; if (send_req !== 1'b1 || send_data !== 8'h00) begin bad++; $display("FAIL fill_in_flight: got req=%b data=%h want req=1 data=00", send_req, send_data); end
    wr_data = 8'h11;
    @(negedge clk);
    wr_valid = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    total++; if (level !== 5'd16) begin bad++; $display("FAIL ovf_level: got %0d want 16", level); end
    overflow_clear = 1'b1;
    @(negedge clk);
    overflow_clear = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    wr_valid = 1'b1; overflow_clear = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; overflow_clear = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    overflow_clear = 1'b1;
    @(negedge clk);
    overflow_clear = 1'b0;
  endtask

  task automatic test_full_pop_push();
    send_busy = 1'b0;
    @(negedge clk);
    total++; if (level !== 5'd16 || send_req !== 1'b0) begin bad++; $display("FAIL fp_release: got level=%0d req=%b want 16/0", level, send_req); end
    send_busy = 1'b1; wr_data = 8'hC0; wr_valid = 1'b1;
    @(negedge clk);
    total++; if (level !== 5'd15) begin bad++; $display("FAIL fp_push_refused: got level=%0d want 15", level); end
    total++; if (send_req !== 1'b1 || send_data !== 8'h01) begin bad++; $display("FAIL fp_pop_data: got req=%b data=%h want 1/01", send_req, send_data); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fp_overflow: got %b want 1", overflow); end
    @(negedge clk);
    wr_valid = 1'b0;
    total++; if (level !== 5'd16 || wr_ready !== 1'b0) begin bad++; $display("FAIL fp_push_accept: got level=%0d rdy=%b want 16/0", level, wr_ready); end
    overflow_clear = 1'b1; flush = 1'b1;
    @(negedge clk);
    overflow_clear = 1'b0; flush = 1'b0; send_busy = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (level !== 5'd0 || send_req !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL fp_cleanup: got level=%0d req=%b ovf=%b want 0/0/0", level, send_req, overflow); end
  endtask

  task automatic test_flush();
    int stray;
    send_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h50 + 8'(i); wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    total++; if (level !== 5'd4) begin bad++; $display("FAIL fl_pre_level: got %0d want 4", level); end
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'hEE;
    @(negedge clk);
    flush = 1'b0; wr_valid = 1'b0;
    total++; if (level !== 5'd0) begin bad++; $display("FAIL fl_level: got %0d want 0", level); end
    total++; if (send_req !== 1'b1 || send_data !== 8'h50) begin bad++; $display("FAIL fl_in_flight: got req=%b data=%h want 1/50", send_req, send_data); end
    send_busy = 1'b0;
    @(negedge clk);
    total++; if (send_req !== 1'b0) begin bad++; $display("FAIL fl_handshake: got %b want 0", send_req); end
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (send_req !== 1'b0) stray++;
    end
    total++; if (stray != 0 || level !== 5'd0) begin bad++; $display("FAIL fl_quiet: got %0d stray reqs level=%0d want 0/0", stray, level); end
    wr_data = 8'hA5; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    total++; if (send_req !== 1'b1 || send_data !== 8'hA5) begin bad++; $display("FAIL fl_new_byte: got req=%b data=%h want 1/a5", send_req, send_data); end
    @(negedge clk);
    total++; if (send_req !== 1'b0 || level !== 5'd0) begin bad++; $display("FAIL fl_new_done: got req=%b level=%0d want 0/0", send_req, level); end
  endtask

  task automatic test_async_reset();
    send_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'h60 + 8'(i); wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    total++; if (level !== 5'd3 || send_req !== 1'b1) begin bad++; $display("FAIL ar_pre: got level=%0d req=%b want 3/1", level, send_req); end
    #2 reset = 1'b1;
    #1;
    total++; if (send_req !== 1'b0 || level !== 5'd0) begin bad++; $display("FAIL ar_immediate: got req=%b level=%0d want 0/0", send_req, level); end
    total++; if (wr_ready !== 1'b1 || send_data !== 8'h00) begin bad++; $display("FAIL ar_outputs: got rdy=%b data=%h want 1/00", wr_ready, send_data); end
    @(negedge clk);
    reset = 1'b0; send_busy = 1'b0;
    wr_data = 8'h77; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    total++; if (send_req !== 1'b0 || level !== 5'd1) begin bad++; $display("FAIL ar_push: got req=%b level=%0d want 0/1", send_req, level); end
    @(negedge clk);
    total++; if (send_req !== 1'b1 || send_data !== 8'h77) begin bad++; $display("FAIL ar_idle_pop: got req=%b data=%h want 1/77", send_req, send_data); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    rx_q.delete(); unstable = 0; stab_prev_req = 1'b0;
    fork
      begin
        logic rdy;
        int   waited;
        for (int i = 0; i < 40; i++) begin
          wr_data = 8'h30 + 8'(i); wr_valid = 1'b1;
          waited = 0;
          do begin
            rdy = wr_ready;
            @(negedge clk);
            waited++;
          end while (!rdy && waited < 2000);
          if (!rdy) begin
            total++; bad++;
            $display("FAIL st_push_timeout: byte %0d stuck, wr_ready=%b want 1", i, wr_ready);
            break;
          end
        end
        wr_valid = 1'b0;
      end
      uart_model(40, 0, 1'b1);
    join
    total++; if (rx_q.size() != 40) begin bad++; $display("FAIL st_count: got %0d want 40", rx_q.size()); end
    for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== 8'h30 + 8'(i)) begin
        bad++; $display("FAIL st_byte%0d: got %h want %h", i, rx_q[i], 8'h30 + 8'(i));
      end
    end
    total++; if (unstable != 0 || level !== 5'd0) begin bad++; $display("FAIL st_end: got changes=%0d level=%0d want 0/0", unstable, level); end
  endtask

  initial begin
    test_reset();
    test_hi();
    test_fill_overflow();
    test_full_pop_push();
    test_flush();
    test_async_reset();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
